alu_multiciclo: RTL and testbench
=================================

// Module: alu_multiciclo
// PURPOSE
//  Parametrised, registered successor to the single-cycle datapath ALU.
//  - Single-cycle ops: integer add/sub, compare, logic and shift, result 1 cycle after accept.
//  - Iterative unsigned ops: MUL, MULHU, DIVU, REMU, result WIDTH cycles after accept.
//  - Sits between the register-file operand muxes and the writeback mux; the control unit
//    stalls the core on READY=0 and captures RESULTADO on VALID_OUT=1.
// PARAMETERS
//  WIDTH   32   operand/result width; any value >= 4.
//  CNT_W   $clog2(WIDTH)+1 (localparam, derived)   iteration counter width.
// PORTS
//  CLK        in   1      system clock; all state updates on rising edge.
//  RESET      in   1      asynchronous, active-high reset.
//  VALID_IN   in   1      operands and CONTROL are valid this cycle.
//  READY      out  1      block can accept; high only in IDLE.
//  CONTROL    in   4      operation select (table below).
//  X, Y       in   WIDTH  operands.
//  RESULTADO  out  WIDTH  registered result; holds its value until the next result is written.
//  ZERO       out  1      1 iff RESULTADO == 0; combinational from the RESULTADO register.
//  VALID_OUT  out  1      one-cycle pulse when RESULTADO is updated.
// BEHAVIOUR
//  Reset (async): state=IDLE, READY=1, RESULTADO=0, ZERO=1, VALID_OUT=0, counter=0.
//   Reset mid-iteration aborts the operation; no VALID_OUT is produced for it.
//  Accept: VALID_IN && READY sampled at a rising edge. VALID_IN while READY=0 is ignored and not queued.
//  CONTROL: shifts use Y[CNT_W-2:0] only; compares return 1/0, zero-extended.
//   0000 ADD    X+Y, mod 2^WIDTH.
//   0111 SUB    X-Y, mod 2^WIDTH.
//   0100 SLT    signed X<Y.
//   0101 SLTU   unsigned X<Y.
//   0010 AND
//   0001 OR
//   1001 XOR
//   0110 PASSB  Y.
//   1000 SLL
//   1010 SRL    logical.
//   1110 SRA    arithmetic; sign of X is replicated.
//   1100 MUL    low WIDTH bits of X*Y; multi-cycle.
//   1101 MULHU  high WIDTH bits of unsigned X*Y; multi-cycle.
//   0011 DIVU   unsigned X/Y; multi-cycle.
//   1011 REMU   unsigned X%Y; multi-cycle.
//   1111 undefined code: result 0, single-cycle latency.
//  Single-cycle path:
//   - Accept at edge k: RESULTADO written and VALID_OUT=1 at edge k; READY stays 1.
//   - Back-to-back accepts every cycle are allowed.
//  Multi-cycle FSM, states IDLE and ITER:
//   - IDLE -> ITER on accepting a multi-cycle op at edge k.
//     X, Y and op are latched, counter=0, READY=0 from edge k.
//   - ITER: one shift-add (MUL/MULHU, 2*WIDTH-bit accumulator) or restoring-divide step
//     (quotient/remainder registers) per edge; counter increments.
//   - At edge k+WIDTH (counter reaches WIDTH-1 step):
//     RESULTADO written, VALID_OUT=1, state -> IDLE, READY=1.
//   - New accept possible at edge k+WIDTH+1, so READY is low for exactly WIDTH cycles.
//  Divide by zero:
//   - DIVU returns all ones; REMU returns X. No trap.
//   - Latency is still WIDTH.
//  VALID_OUT is 0 in every cycle not listed above. RESULTADO is unchanged while in ITER.
// TESTING (WIDTH=32 unless stated)
//  1. RESET high mid-MUL at iteration 10 -> READY=1, VALID_OUT=0, RESULTADO=0, ZERO=1 immediately.
//     After release, ADD 1+1 -> 2.
//  2. Back-to-back single-cycle ops, one per cycle:
//     - ADD 0xFFFFFFFF+1 -> 0, ZERO=1.
//     - SLT 0xFFFFFFFF,1 -> 1.
//     - SLTU 0xFFFFFFFF,1 -> 0.
//     - SRA 0x80000000,Y=0x21 -> 0xC0000000 (shift by 1).
//     Expect 4 consecutive VALID_OUT pulses.
//  3. MUL and MULHU on 0xFFFFFFFF, 0xFFFFFFFF:
//     - MUL -> 0x00000001.
//     - MULHU -> 0xFFFFFFFE.
//     - VALID_OUT exactly 32 edges after accept; READY low 32 cycles.
//  4. Divide:
//     - DIVU 100,7 -> 14; REMU 100,7 -> 2.
//     - DIVU 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
//  5. Ignored request: VALID_IN=1 with ADD 3+4 held during ITER -> ignored.
//     It is accepted on the first READY=1 edge; RESULTADO=7 one edge later.
//  6. Width scaling, WIDTH=8:
//     - MULHU 0xFF,0xFF -> 0xFE, 8-cycle latency.
//     - Random 10k ops compared against a reference model.

Source files
------------

// File: rtl/alu_multiciclo_if.sv
// Handshake and operand/result bundle between the control unit and alu_multiciclo.
// The control unit drives the master side; the ALU implements the slave side.
interface alu_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             VALID_IN;
  logic             READY;
  logic [3:0]       CONTROL;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] RESULTADO;
  logic             ZERO;
  logic             VALID_OUT;

  modport master (
    output VALID_IN, CONTROL, X, Y,
    input  READY, RESULTADO, ZERO, VALID_OUT
  );

  modport slave (
    input  VALID_IN, CONTROL, X, Y,
    output READY, RESULTADO, ZERO, VALID_OUT
  );
endinterface

// File: rtl/alu_multiciclo.sv
// Registered ALU: single-cycle integer/logic/shift ops plus iterative unsigned
// multiply (shift-add) and divide (restoring), one step per clock for WIDTH clocks.
module alu_multiciclo #(
  parameter int WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  alu_multiciclo_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int SH_W  = CNT_W - 1;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_AND   = 4'b0010,
    OP_DIVU  = 4'b0011,
    OP_SLT   = 4'b0100,
    OP_SLTU  = 4'b0101,
    OP_PASSB = 4'b0110,
    OP_SUB   = 4'b0111,
    OP_SLL   = 4'b1000,
    OP_XOR   = 4'b1001,
    OP_SRL   = 4'b1010,
    OP_REMU  = 4'b1011,
    OP_MUL   = 4'b1100,
    OP_MULHU = 4'b1101,
    OP_SRA   = 4'b1110,
    OP_UNDEF = 4'b1111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_ITER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  op_e                op_q, op_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // multiplicand (MUL*) or divisor (DIV/REM)
  logic [WIDTH-1:0]   hi_q, hi_d;       // product high half or partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;       // multiplier/product low half or dividend/quotient
  logic [WIDTH-1:0]   res_q, res_d;
  logic               vout_q, vout_d;

  op_e                op_in;
  logic               in_multi;
  logic               in_div;
  logic               ready;
  logic               accept;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   alu_res;

  logic               q_div;
  logic               last_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   step_hi;
  logic [WIDTH-1:0]   step_lo;

  assign op_in    = op_e'(bus.CONTROL);
  assign in_multi = (op_in == OP_MUL) || (op_in == OP_MULHU) ||
                    (op_in == OP_DIVU) || (op_in == OP_REMU);
  assign in_div   = (op_in == OP_DIVU) || (op_in == OP_REMU);
  assign ready    = (state_q == S_IDLE);
  assign accept   = bus.VALID_IN && ready;
  assign shamt    = bus.Y[SH_W-1:0];

  // Single-cycle datapath, evaluated directly on the incoming operands.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    alu_res = '0;
    unique case (op_in)
      OP_ADD:   alu_res = bus.X + bus.Y;
      OP_SUB:   alu_res = bus.X - bus.Y;
      OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.X) < $signed(bus.Y))};
      OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (bus.X < bus.Y)};
      OP_AND:   alu_res = bus.X & bus.Y;
      OP_OR:    alu_res = bus.X | bus.Y;
      OP_XOR:   alu_res = bus.X ^ bus.Y;
      OP_PASSB: alu_res = bus.Y;
      OP_SLL:   alu_res = bus.X << shamt;
      OP_SRL:   alu_res = bus.X >> shamt;
      OP_SRA:   alu_res = $signed(bus.X) >>> shamt;
      default:  alu_res = '0;
    endcase
  end

  // One iteration step. Multiply: add multiplicand if lo[0], then shift {carry,hi,lo}
  // right. Divide: shift the next dividend bit into the remainder and subtract if it fits.
  // With a zero divisor every step "fits", giving an all-ones quotient and remainder X.
  assign q_div     = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});
  assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;
  assign step_hi   = q_div ? (div_ge ? div_diff : div_shift[WIDTH-1:0])
                           : mul_sum[WIDTH:1];
  assign step_lo   = q_div ? {lo_q[WIDTH-2:0], div_ge}
                           : {mul_sum[0], lo_q[WIDTH-1:1]};

  // State register (FSM state plus the datapath it sequences).
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_ADD;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      vout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge
      // values; blocking would let later flops see values updated this same edge.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      vout_q  <= vout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept && in_multi) state_d = S_ITER;
      S_ITER: if (last_step)          state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Output and datapath-update logic.
  always_comb begin
    op_d   = op_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    res_d  = res_q;
    vout_d = 1'b0;

    if (accept && !in_multi) begin
      res_d  = alu_res;
      vout_d = 1'b1;
    end else if (accept) begin
      op_d   = op_in;
      opnd_d = in_div ? bus.Y : bus.X;
      lo_d   = in_div ? bus.X : bus.Y;
      hi_d   = '0;
      cnt_d  = '0;
    end

    if (state_q == S_ITER) begin
      hi_d  = step_hi;
      lo_d  = step_lo;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) begin
        res_d  = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? step_lo : step_hi;
        vout_d = 1'b1;
        cnt_d  = '0;
      end
    end
  end

  assign bus.READY     = ready;
  assign bus.RESULTADO = res_q;
  assign bus.ZERO      = (res_q == '0);
  assign bus.VALID_OUT = vout_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed and randomised checks of alu_multiciclo at WIDTH=32 and WIDTH=8.
module tb_alu_multiciclo;

  localparam logic [3:0] C_ADD   = 4'b0000;
  localparam logic [3:0] C_OR    = 4'b0001;
  localparam logic [3:0] C_AND   = 4'b0010;
  localparam logic [3:0] C_DIVU  = 4'b0011;
  localparam logic [3:0] C_SLT   = 4'b0100;
  localparam logic [3:0] C_SLTU  = 4'b0101;
  localparam logic [3:0] C_PASSB = 4'b0110;
  localparam logic [3:0] C_SUB   = 4'b0111;
  localparam logic [3:0] C_SLL   = 4'b1000;
  localparam logic [3:0] C_XOR   = 4'b1001;
  localparam logic [3:0] C_SRL   = 4'b1010;
  localparam logic [3:0] C_REMU  = 4'b1011;
  localparam logic [3:0] C_MUL   = 4'b1100;
  localparam logic [3:0] C_MULHU = 4'b1101;
  localparam logic [3:0] C_SRA   = 4'b1110;
  localparam logic [3:0] C_UNDEF = 4'b1111;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp_res;
  } vec_t;

  logic CLK = 1'b0;
  logic RESET;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  alu_multiciclo_if #(.WIDTH(32)) if32 ();
  alu_multiciclo_if #(.WIDTH(8))  if8 ();

  alu_multiciclo #(.WIDTH(32)) dut32 (.CLK(CLK), .RESET(RESET), .bus(if32.slave));
  alu_multiciclo #(.WIDTH(8))  dut8  (.CLK(CLK), .RESET(RESET), .bus(if8.slave));

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] c);
    return (c == C_MUL) || (c == C_MULHU) || (c == C_DIVU) || (c == C_REMU);
  endfunction

  // Independent 8-bit reference using native operators.
  function automatic logic [7:0] ref8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic [2:0]  sh;
    p  = {8'h00, a} * {8'h00, b};
    sh = b[2:0];
    case (c)
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_SLT:   return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
      C_SLTU:  return (a < b) ? 8'd1 : 8'd0;
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_XOR:   return a ^ b;
      C_PASSB: return b;
      C_SLL:   return a << sh;
      C_SRL:   return a >> sh;
      C_SRA:   return $signed(a) >>> sh;
      C_MUL:   return p[7:0];
      C_MULHU: return p[15:8];
      C_DIVU:  return (b == 8'd0) ? 8'hFF : a / b;
      C_REMU:  return (b == 8'd0) ? a : a % b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic drive(input bit narrow, input logic v, input logic [3:0] c,
                       input logic [31:0] x, input logic [31:0] y);
    if (narrow) begin
      if8.VALID_IN = v; if8.CONTROL = c; if8.X = x[7:0]; if8.Y = y[7:0];
    end else begin
      if32.VALID_IN = v; if32.CONTROL = c; if32.X = x; if32.Y = y;
    end
  endtask

  task automatic sample(input bit narrow, output logic vout, output logic rdy,
                        output logic zero, output logic [31:0] res);
    if (narrow) begin
      vout = if8.VALID_OUT; rdy = if8.READY; zero = if8.ZERO; res = {24'h0, if8.RESULTADO};
    end else begin
      vout = if32.VALID_OUT; rdy = if32.READY; zero = if32.ZERO; res = if32.RESULTADO;
    end
  endtask

  // Issue one op (READY assumed high) and wait, bounded, for its VALID_OUT.
  // lat counts edges from the accept edge to the result edge; rdy_low counts samples with READY=0.
  task automatic do_op(input bit narrow, input logic [3:0] c, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] res, output logic zero,
                       output int lat, output int rdy_low);
    logic vout, rdy;
    drive(narrow, 1'b1, c, x, y);
    @(posedge CLK); #1;
    drive(narrow, 1'b0, c, x, y);
    lat = 0;
    rdy_low = 0;
    sample(narrow, vout, rdy, zero, res);
    if (!rdy) rdy_low++;
    while (!vout && lat < 64) begin
      @(posedge CLK); #1;
      lat++;
      sample(narrow, vout, rdy, zero, res);
      if (!rdy) rdy_low++;
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] res, exp_r;
  logic        zero, vout, rdy;
  int          lat, rdy_low, exp_lat, pulses;
  logic [3:0]  rc;
  logic [7:0]  rx, ry;

  initial begin
    vecs.push_back('{C_ADD,   32'd5,        32'd7,        32'd12});
    vecs.push_back('{C_ADD,   32'hFFFFFFFF, 32'd1,        32'h0});
    vecs.push_back('{C_SUB,   32'd3,        32'd5,        32'hFFFFFFFE});
    vecs.push_back('{C_SUB,   32'd10,       32'd10,       32'h0});
    vecs.push_back('{C_SLT,   32'hFFFFFFFF, 32'd1,        32'd1});
    vecs.push_back('{C_SLT,   32'd1,        32'hFFFFFFFF, 32'd0});
    vecs.push_back('{C_SLTU,  32'hFFFFFFFF, 32'd1,        32'd0});
    vecs.push_back('{C_SLTU,  32'd1,        32'hFFFFFFFF, 32'd1});
    vecs.push_back('{C_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000});
    vecs.push_back('{C_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0});
    vecs.push_back('{C_XOR,   32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F});
    vecs.push_back('{C_PASSB, 32'd0,        32'h12345678, 32'h12345678});
    vecs.push_back('{C_SLL,   32'd1,        32'd31,       32'h80000000});
    vecs.push_back('{C_SLL,   32'd3,        32'h21,       32'd6});
    vecs.push_back('{C_SRL,   32'h80000000, 32'd31,       32'd1});
    vecs.push_back('{C_SRA,   32'h80000000, 32'h21,       32'hC0000000});
    vecs.push_back('{C_SRA,   32'h7FFFFFF0, 32'd4,        32'h07FFFFFF});
    vecs.push_back('{C_UNDEF, 32'd5,        32'd6,        32'h0});
    vecs.push_back('{C_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{C_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{C_MUL,   32'd1000,     32'd1000,     32'h000F4240});
    vecs.push_back('{C_MUL,   32'h10000,    32'h10000,    32'h0});
    vecs.push_back('{C_MULHU, 32'h10000,    32'h10000,    32'h1});
    vecs.push_back('{C_DIVU,  32'd100,      32'd7,        32'd14});
    vecs.push_back('{C_REMU,  32'd100,      32'd7,        32'd2});
    vecs.push_back('{C_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF});
    vecs.push_back('{C_REMU,  32'd5,        32'd0,        32'd5});
    vecs.push_back('{C_DIVU,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF});
    vecs.push_back('{C_REMU,  32'd7,        32'd100,      32'd7});
    vecs.push_back('{C_DIVU,  32'd0,        32'd3,        32'd0});

    drive(1'b0, 1'b0, C_ADD, 32'd0, 32'd0);
    drive(1'b1, 1'b0, C_ADD, 32'd0, 32'd0);
    RESET = 1'b1;
    #12;
    sample(1'b0, vout, rdy, zero, res);
    check("reset READY", rdy, 1);
    check("reset VALID_OUT", vout, 0);
    check("reset RESULTADO", res, 0);
    check("reset ZERO", zero, 1);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Directed table at WIDTH=32.
    foreach (vecs[i]) begin
      do_op(1'b0, vecs[i].ctrl, vecs[i].x, vecs[i].y, res, zero, lat, rdy_low);
      exp_lat = is_multi(vecs[i].ctrl) ? 32 : 0;
      check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d zero", i), zero, (vecs[i].exp_res == 32'h0));
      check($sformatf("vec%0d latency", i), lat, exp_lat);
      check($sformatf("vec%0d ready_low", i), rdy_low, exp_lat);
    end

    // Back-to-back single-cycle ops, one accept per edge.
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1'b0, 1'b1, C_ADD,  32'hFFFFFFFF, 32'd1);  exp_r = 32'h0;        end
        1: begin drive(1'b0, 1'b1, C_SLT,  32'hFFFFFFFF, 32'd1);  exp_r = 32'h1;        end
        2: begin drive(1'b0, 1'b1, C_SLTU, 32'hFFFFFFFF, 32'd1);  exp_r = 32'h0;        end
        default: begin drive(1'b0, 1'b1, C_SRA, 32'h80000000, 32'h21); exp_r = 32'hC0000000; end
      endcase
      @(posedge CLK); #1;
      sample(1'b0, vout, rdy, zero, res);
      check($sformatf("b2b%0d VALID_OUT", i), vout, 1);
      check($sformatf("b2b%0d READY", i), rdy, 1);
      check($sformatf("b2b%0d result", i), res, exp_r);
      check($sformatf("b2b%0d zero", i), zero, (exp_r == 32'h0));
    end
    drive(1'b0, 1'b0, C_ADD, 32'd0, 32'd0);
    @(posedge CLK); #1;
    sample(1'b0, vout, rdy, zero, res);
    check("b2b pulse ends", vout, 0);

    // A request held during ITER is ignored, then taken on the first READY edge.
    drive(1'b0, 1'b1, C_MUL, 32'd6, 32'd7);
    @(posedge CLK); #1;
    drive(1'b0, 1'b1, C_ADD, 32'd3, 32'd4);
    lat = 0;
    pulses = 0;
    vout = 1'b0;
    while (!vout && lat < 64) begin
      @(posedge CLK); #1;
      lat++;
      sample(1'b0, vout, rdy, zero, res);
    end
    check("held req mul latency", lat, 32);
    check("held req mul result", res, 32'd42);
    @(posedge CLK); #1;
    sample(1'b0, vout, rdy, zero, res);
    check("held req accepted VALID_OUT", vout, 1);
    check("held req accepted result", res, 32'd7);
    drive(1'b0, 1'b0, C_ADD, 32'd0, 32'd0);
    @(posedge CLK); #1;
    sample(1'b0, vout, rdy, zero, res);
    check("held req pulse ends", vout, 0);

    // Reset in the middle of a MUL aborts it.
    drive(1'b0, 1'b1, C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(posedge CLK); #1;
    drive(1'b0, 1'b0, C_ADD, 32'd0, 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    sample(1'b0, vout, rdy, zero, res);
    check("pre-abort READY", rdy, 0);
    RESET = 1'b1;
    #1;
    sample(1'b0, vout, rdy, zero, res);
    check("abort READY", rdy, 1);
    check("abort VALID_OUT", vout, 0);
    check("abort RESULTADO", res, 0);
    check("abort ZERO", zero, 1);
    @(negedge CLK);
    RESET = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (if32.VALID_OUT) pulses++;
    end
    check("abort no late VALID_OUT", pulses, 0);
    do_op(1'b0, C_ADD, 32'd1, 32'd1, res, zero, lat, rdy_low);
    check("post-abort add", res, 32'd2);
    check("post-abort latency", lat, 0);

    // WIDTH=8 instance.
    do_op(1'b1, C_MULHU, 32'hFF, 32'hFF, res, zero, lat, rdy_low);
    check("w8 mulhu result", res, 32'hFE);
    check("w8 mulhu latency", lat, 8);
    check("w8 mulhu ready_low", rdy_low, 8);

    for (int i = 0; i < 10000; i++) begin
      rc = 4'($urandom_range(0, 15));
      rx = 8'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_op(1'b1, rc, {24'h0, rx}, {24'h0, ry}, res, zero, lat, rdy_low);
      check($sformatf("w8 rand%0d op%0h %0h,%0h result", i, rc, rx, ry), res, {24'h0, ref8(rc, rx, ry)});
      check($sformatf("w8 rand%0d latency", i), lat, is_multi(rc) ? 8 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
